rename_checkpoint_ctrl: RTL and testbench



---
 rtl/rename_checkpoint_ctrl_pkg.sv | 17 +
 rtl/rename_checkpoint_ctrl_cp_slot_tracker.sv | 101 ++++++++++
 rtl/rename_checkpoint_ctrl.sv | 145 ++++++++++++++
 tb/tb_rename_checkpoint_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/rename_checkpoint_ctrl_pkg.sv
// Shared definitions for the rename checkpoint controller and the rename stage.
package rename_checkpoint_ctrl_pkg;

  // Number of branch checkpoint slots shared with rename (power of two, 2..16).
  localparam int NUM_CP = 4;

  // Checkpoint slot identifier.
  typedef logic [$clog2(NUM_CP)-1:0] cp_id_t;

  // Recovery sequencer states.
  typedef enum logic [1:0] {
    CP_IDLE    = 2'd0,
    CP_RESTORE = 2'd1,
    CP_FLUSH   = 2'd2
  } cp_state_t;

endpackage

// File: rtl/rename_checkpoint_ctrl_cp_slot_tracker.sv
// Circular-buffer bookkeeping for branch checkpoints: head/tail pointers,
// per-slot valid bits, occupancy, in-order head drain and squash range clear.
module cp_slot_tracker #(
  parameter int NUM_CP  = 4,
  parameter int CP_BITS = $clog2(NUM_CP)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alloc_i,
  input  logic               free_i,
  input  logic [CP_BITS-1:0] free_id_i,
  input  logic               squash_i,
  input  logic [CP_BITS-1:0] squash_id_i,
  output logic [CP_BITS-1:0] tail_o,
  output logic [NUM_CP-1:0]  valid_o,
  output logic [CP_BITS:0]   occ_o
);
  import rename_checkpoint_ctrl_pkg::*;

  localparam logic [CP_BITS-1:0] ID_ONE  = CP_BITS'(1);
  localparam logic [CP_BITS:0]   OCC_ONE = (CP_BITS+1)'(1);

  logic [CP_BITS-1:0] head_q, head_d;
  logic [CP_BITS-1:0] tail_q, tail_d;
  logic [NUM_CP-1:0]  valid_q, valid_d;
  logic [CP_BITS:0]   occ_q, occ_d;
  logic [CP_BITS:0]   older_s;
  logic [CP_BITS:0]   squash_len_s;
  logic [CP_BITS:0]   off_s;
  logic               adv_s;

  // Next-state bookkeeping: squash takes priority over allocate/free/drain.
  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    valid_d      = valid_q;
    occ_d        = occ_q;
    off_s        = '0;
    adv_s        = 1'b0;
    // Slots older than the mispredicted one survive; the rest (k..tail-1) go.
    older_s      = {1'b0, squash_id_i - head_q};
    squash_len_s = occ_q - older_s;
    if (squash_i) begin
      for (int i = 0; i < NUM_CP; i++) begin
        off_s = {1'b0, CP_BITS'(i) - squash_id_i};
        if (off_s < squash_len_s) begin
          valid_d[i] = 1'b0;
        end else begin
          valid_d[i] = valid_q[i];
        end
      end
      tail_d = squash_id_i;
      occ_d  = older_s;
    end else begin
      // A head slot freed this cycle drains immediately so it is reusable next cycle.
      adv_s = (occ_q != '0) &&
              (!valid_q[head_q] || (free_i && (free_id_i == head_q)));
      if (free_i) begin
        valid_d[free_id_i] = 1'b0;
      end else begin
        valid_d = valid_d;
      end
      if (alloc_i) begin
        valid_d[tail_q] = 1'b1;
        tail_d          = tail_q + ID_ONE;
      end else begin
        tail_d = tail_q;
      end
      if (adv_s) begin
        head_d = head_q + ID_ONE;
      end else begin
        head_d = head_q;
      end
      case ({alloc_i, adv_s})
        2'b10:   occ_d = occ_q + OCC_ONE;
        2'b01:   occ_d = occ_q - OCC_ONE;
        default: occ_d = occ_q;
      endcase
    end
  end

  // Bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  assign tail_o  = tail_q;
  assign valid_o = valid_q;
  assign occ_o   = occ_q;

endmodule

// File: rtl/rename_checkpoint_ctrl.sv
// Branch checkpoint controller: grants checkpoint slots to renamed branches,
// frees them on correct resolution and sequences restore/flush on mispredict.
module rename_checkpoint_ctrl #(
  parameter int NUM_CP       = rename_checkpoint_ctrl_pkg::NUM_CP,
  parameter int CP_BITS      = $clog2(NUM_CP),
  parameter int FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               br_valid,
  output logic               br_ready,
  output logic               capture,
  output logic [CP_BITS-1:0] capture_id,
  output logic               decode_stall,
  input  logic               resolve_valid,
  input  logic [CP_BITS-1:0] resolve_id,
  input  logic               resolve_mispred,
  output logic               restore,
  output logic [CP_BITS-1:0] restore_id,
  output logic               flush,
  output logic [CP_BITS:0]   cp_count
);
  import rename_checkpoint_ctrl_pkg::*;

  localparam logic [CP_BITS:0] OCC_FULL   = (CP_BITS+1)'(NUM_CP);
  localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES);

  cp_state_t          state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               restore_q, restore_d;
  logic [CP_BITS-1:0] restore_id_q, restore_id_d;
  logic               flush_q, flush_d;

  logic [CP_BITS-1:0] tail_s;
  logic [NUM_CP-1:0]  valid_s;
  logic [CP_BITS:0]   occ_s;
  logic               idle_s;
  logic               id_valid_s;
  logic               mispred_s;
  logic               free_s;
  logic               alloc_s;

  // Resolves only count in IDLE and only for live slots.
  assign idle_s     = (state_q == CP_IDLE);
  assign id_valid_s = valid_s[resolve_id];
  assign mispred_s  = resolve_valid & resolve_mispred & id_valid_s & idle_s;
  assign free_s     = resolve_valid & ~resolve_mispred & id_valid_s & idle_s;

  // Any mispredict report blocks allocation that cycle, even one later ignored.
  assign br_ready     = idle_s & (occ_s < OCC_FULL) & ~(resolve_valid & resolve_mispred);
  assign alloc_s      = br_valid & br_ready;
  assign capture      = alloc_s;
  assign capture_id   = tail_s;
  assign decode_stall = br_valid & ~br_ready;
  assign cp_count     = occ_s;

  cp_slot_tracker #(
    .NUM_CP  (NUM_CP),
    .CP_BITS (CP_BITS)
  ) u_tracker (
    .clk         (clk),
    .rst         (rst),
    .alloc_i     (alloc_s),
    .free_i      (free_s),
    .free_id_i   (resolve_id),
    .squash_i    (mispred_s),
    .squash_id_i (resolve_id),
    .tail_o      (tail_s),
    .valid_o     (valid_s),
    .occ_o       (occ_s)
  );

  // State and flush-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CP_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: one RESTORE cycle, then FLUSH_CYCLES of FLUSH.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CP_IDLE: begin
        cnt_d = 4'd0;
        if (mispred_s) begin
          state_d = CP_RESTORE;
        end else begin
          state_d = CP_IDLE;
        end
      end
      CP_RESTORE: begin
        state_d = CP_FLUSH;
        cnt_d   = FLUSH_LOAD;
      end
      CP_FLUSH: begin
        if (cnt_q <= 4'd1) begin
          state_d = CP_IDLE;
          cnt_d   = 4'd0;
        end else begin
          state_d = CP_FLUSH;
          cnt_d   = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = CP_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Output decode from the upcoming state so outputs are registered.
  always_comb begin
    restore_d = (state_d == CP_RESTORE);
    flush_d   = (state_d != CP_IDLE);
    if (mispred_s) begin
      restore_id_d = resolve_id;
    end else begin
      restore_id_d = restore_id_q;
    end
  end

  // Registered recovery outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      restore_q    <= 1'b0;
      restore_id_q <= '0;
      flush_q      <= 1'b0;
    end else begin
      restore_q    <= restore_d;
      restore_id_q <= restore_id_d;
      flush_q      <= flush_d;
    end
  end

  assign restore    = restore_q;
  assign restore_id = restore_id_q;
  assign flush      = flush_q;

endmodule

// File: tb/tb_rename_checkpoint_ctrl.sv
// Directed vector bench for rename_checkpoint_ctrl (NUM_CP=4, FLUSH_CYCLES=2).
module tb_rename_checkpoint_ctrl;

  logic       clk;
  logic       rst;
  logic       br_valid;
  logic       br_ready;
  logic       capture;
  logic [1:0] capture_id;
  logic       decode_stall;
  logic       resolve_valid;
  logic [1:0] resolve_id;
  logic       resolve_mispred;
  logic       restore;
  logic [1:0] restore_id;
  logic       flush;
  logic [2:0] cp_count;

  int total;
  int bad;

  rename_checkpoint_ctrl #(
    .NUM_CP       (4),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .br_valid        (br_valid),
    .br_ready        (br_ready),
    .capture         (capture),
    .capture_id      (capture_id),
    .decode_stall    (decode_stall),
    .resolve_valid   (resolve_valid),
    .resolve_id      (resolve_id),
    .resolve_mispred (resolve_mispred),
    .restore         (restore),
    .restore_id      (restore_id),
    .flush           (flush),
    .cp_count        (cp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus and the outputs expected while it is applied.
  typedef struct {
    logic       bv;
    logic       rv;
    logic [1:0] rid;
    logic       mp;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[24];

  // exp packs {br_ready, capture, capture_id, decode_stall, restore, restore_id, flush, cp_count}.
  function automatic vec_t mk(input logic bv, input logic rv, input logic [1:0] rid, input logic mp,
                              input logic rdy, input logic cap, input logic [1:0] cid, input logic stl,
                              input logic rs, input logic [1:0] rsid, input logic fl, input logic [2:0] cnt);
    vec_t v;
    v.bv  = bv;
    v.rv  = rv;
    v.rid = rid;
    v.mp  = mp;
    v.exp = {rdy, cap, cid, stl, rs, rsid, fl, cnt};
    return v;
  endfunction

  function automatic logic [11:0] outs();
    return {br_ready, capture, capture_id, decode_stall, restore, restore_id, flush, cp_count};
  endfunction

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b (rdy,cap,cid,stall,restore,rid,flush,cnt)", name, got, want);
    end
  endtask

  task automatic drive(input logic bv, input logic rv, input logic [1:0] rid, input logic mp);
    @(negedge clk);
    br_valid        = bv;
    resolve_valid   = rv;
    resolve_id      = rid;
    resolve_mispred = mp;
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst             = 1'b1;
    br_valid        = 1'b0;
    resolve_valid   = 1'b0;
    resolve_id      = 2'd0;
    resolve_mispred = 1'b0;

    //                 bv rv rid mp   rdy cap cid stl rs rsid fl cnt
    // fill 0..3 then full
    vecs[0]  = mk(1'b1,1'b0,2'd0,1'b0, 1'b1,1'b1,2'd0,1'b0,1'b0,2'd0,1'b0,3'd0);
    vecs[1]  = mk(1'b1,1'b0,2'd0,1'b0, 1'b1,1'b1,2'd1,1'b0,1'b0,2'd0,1'b0,3'd1);
    vecs[2]  = mk(1'b1,1'b0,2'd0,1'b0, 1'b1,1'b1,2'd2,1'b0,1'b0,2'd0,1'b0,3'd2);
    vecs[3]  = mk(1'b1,1'b0,2'd0,1'b0, 1'b1,1'b1,2'd3,1'b0,1'b0,2'd0,1'b0,3'd3);
    vecs[4]  = mk(1'b1,1'b0,2'd0,1'b0, 1'b0,1'b0,2'd0,1'b1,1'b0,2'd0,1'b0,3'd4);
    // resolve head 0 from full; slot 0 reused next cycle (tail wrapped)
    vecs[5]  = mk(1'b0,1'b1,2'd0,1'b0, 1'b0,1'b0,2'd0,1'b0,1'b0,2'd0,1'b0,3'd4);
    vecs[6]  = mk(1'b1,1'b0,2'd0,1'b0, 1'b1,1'b1,2'd0,1'b0,1'b0,2'd0,1'b0,3'd3);
    // head=1: resolve 3 (hole), then head 1, then 2 drains through the hole
    vecs[7]  = mk(1'b0,1'b1,2'd3,1'b0, 1'b0,1'b0,2'd1,1'b0,1'b0,2'd0,1'b0,3'd4);
    vecs[8]  = mk(1'b0,1'b1,2'd1,1'b0, 1'b0,1'b0,2'd1,1'b0,1'b0,2'd0,1'b0,3'd4);
    vecs[9]  = mk(1'b0,1'b0,2'd0,1'b0, 1'b1,1'b0,2'd1,1'b0,1'b0,2'd0,1'b0,3'd3);
    vecs[10] = mk(1'b0,1'b1,2'd2,1'b0, 1'b1,1'b0,2'd1,1'b0,1'b0,2'd0,1'b0,3'd3);
    vecs[11] = mk(1'b0,1'b0,2'd0,1'b0, 1'b1,1'b0,2'd1,1'b0,1'b0,2'd0,1'b0,3'd2);
    // mispredict on an invalid slot is ignored (but still blocks ready that cycle)
    vecs[12] = mk(1'b0,1'b1,2'd2,1'b1, 1'b0,1'b0,2'd1,1'b0,1'b0,2'd0,1'b0,3'd1);
    vecs[13] = mk(1'b0,1'b0,2'd0,1'b0, 1'b1,1'b0,2'd1,1'b0,1'b0,2'd0,1'b0,3'd1);
    // refill 1..3, then mispredict on 1 together with br_valid
    vecs[14] = mk(1'b1,1'b0,2'd0,1'b0, 1'b1,1'b1,2'd1,1'b0,1'b0,2'd0,1'b0,3'd1);
    vecs[15] = mk(1'b1,1'b0,2'd0,1'b0, 1'b1,1'b1,2'd2,1'b0,1'b0,2'd0,1'b0,3'd2);
    vecs[16] = mk(1'b1,1'b0,2'd0,1'b0, 1'b1,1'b1,2'd3,1'b0,1'b0,2'd0,1'b0,3'd3);
    vecs[17] = mk(1'b1,1'b1,2'd1,1'b1, 1'b0,1'b0,2'd0,1'b1,1'b0,2'd0,1'b0,3'd4);
    // restore, then flush; resolves of 0 meanwhile are ignored
    vecs[18] = mk(1'b1,1'b1,2'd0,1'b0, 1'b0,1'b0,2'd1,1'b1,1'b1,2'd1,1'b1,3'd1);
    vecs[19] = mk(1'b0,1'b1,2'd0,1'b0, 1'b0,1'b0,2'd1,1'b0,1'b0,2'd1,1'b1,3'd1);
    vecs[20] = mk(1'b0,1'b0,2'd0,1'b0, 1'b0,1'b0,2'd1,1'b0,1'b0,2'd1,1'b1,3'd1);
    vecs[21] = mk(1'b1,1'b0,2'd0,1'b0, 1'b1,1'b1,2'd1,1'b0,1'b0,2'd1,1'b0,3'd1);
    // simultaneous allocate + correct resolve of head: count unchanged
    vecs[22] = mk(1'b1,1'b1,2'd0,1'b0, 1'b1,1'b1,2'd2,1'b0,1'b0,2'd1,1'b0,3'd2);
    vecs[23] = mk(1'b0,1'b0,2'd0,1'b0, 1'b1,1'b0,2'd3,1'b0,1'b0,2'd1,1'b0,3'd2);

    // Reset state.
    @(negedge clk);
    #1;
    chk("reset", outs(), 12'b1_1_00_0_0_00_0_000 & 12'b1_0_11_1_1_11_1_111);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven main sequence.
    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].bv, vecs[i].rv, vecs[i].rid, vecs[i].mp);
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Reset in the middle of FLUSH.
    drive(1'b0, 1'b0, 2'd0, 1'b0);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    drive(1'b1, 1'b0, 2'd0, 1'b0);
    drive(1'b1, 1'b0, 2'd0, 1'b0);
    drive(1'b1, 1'b0, 2'd0, 1'b0);
    chk("fill_id2", outs(), {1'b1,1'b1,2'd2,1'b0,1'b0,2'd0,1'b0,3'd2});
    drive(1'b0, 1'b1, 2'd1, 1'b1);
    chk("mp_cycle", outs(), {1'b0,1'b0,2'd3,1'b0,1'b0,2'd0,1'b0,3'd3});
    drive(1'b0, 1'b0, 2'd0, 1'b0);
    chk("restore_cycle", outs(), {1'b0,1'b0,2'd1,1'b0,1'b1,2'd1,1'b1,3'd1});
    drive(1'b1, 1'b0, 2'd0, 1'b0);
    chk("flush_cycle", outs(), {1'b0,1'b0,2'd1,1'b1,1'b0,2'd1,1'b1,3'd1});
    rst = 1'b1;
    #1;
    chk("rst_in_flush", outs(), {1'b1,1'b1,2'd0,1'b0,1'b0,2'd0,1'b0,3'd0});
    drive(1'b1, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_alloc", outs(), {1'b1,1'b1,2'd0,1'b0,1'b0,2'd0,1'b0,3'd0});
    drive(1'b0, 1'b0, 2'd0, 1'b0);
    chk("post_rst_count", outs(), {1'b1,1'b0,2'd1,1'b0,1'b0,2'd0,1'b0,3'd1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
